cellrv32_cpu_cp_muldiv_rn: RTL

Parametrised successor of the CPU "M"-extension co-processor: integer multiply/divide unit with configurable data width (32/64), radix-2^k iterative datapath (1, 2 or 4 result bits per cycle), an optional single-cycle DSP multiplier, and a registered sign-correction stage. Adds single-cycle early-out for division by zero and signed overflow, an explicit busy/valid handshake and an abort input. Sits beside the ALU in the CPU execute stage and is started by the control unit for OP-class instructions with funct7 = 0000001.

---
 rtl/cellrv32_cpu_cp_muldiv_rn.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cellrv32_cpu_cp_muldiv_rn.sv
// Integer multiply/divide co-processor for the RISC-V "M" extension.
// Radix-2^k iterative datapath, optional single-cycle multiplier, registered sign fix-up.
module cellrv32_cpu_cp_muldiv_rn #(
    parameter int unsigned XLEN           = 32,
    parameter bit          FAST_MUL_EN    = 1'b1,
    parameter bit          DIVISION_EN    = 1'b1,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] res_o
);

    localparam int unsigned Steps = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CntW  = $clog2(Steps);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StFin, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                sign_q, sign_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                rs1_signed, rs2_signed, rs1_neg, rs2_neg, sign_in;
    logic [XLEN-1:0]     rs1_abs, rs2_abs;
    logic                div_zero, div_ovf;
    logic [2*XLEN-1:0]   fast_prod, step_acc, prod;
    logic [XLEN:0]       rem_tmp, diff, sum;
    logic [XLEN-1:0]     sel, fin_res;
    logic                neg_en;

    always_comb begin
        rs1_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b100) || (funct3_i == 3'b110);
        rs2_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        rs1_neg    = rs1_signed & rs1_i[XLEN-1];
        rs2_neg    = rs2_signed & rs2_i[XLEN-1];
        rs1_abs    = rs1_neg ? -rs1_i : rs1_i;
        rs2_abs    = rs2_neg ? -rs2_i : rs2_i;
        // Remainder takes the dividend's sign; everything else the XOR of operand signs.
        sign_in    = (funct3_i[2] && funct3_i[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
        div_zero   = (rs2_i == '0);
        div_ovf    = !funct3_i[0] && (rs1_i == MinNeg) && (rs2_i == '1);
        // Low 2*XLEN bits of the extended product equal the signed (XLEN+1)-bit product.
        fast_prod  = {{XLEN{rs1_neg}}, rs1_i} * {{XLEN{rs2_neg}}, rs2_i};
    end

    // BITS_PER_CYCLE chained steps; acc holds {remainder, quotient} or the running product.
    always_comb begin
        step_acc = acc_q;
        rem_tmp  = '0;
        diff     = '0;
        sum      = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (funct3_q[2]) begin
                rem_tmp = step_acc[2*XLEN-1:XLEN-1];
                diff    = rem_tmp - {1'b0, opb_q};
                if (!diff[XLEN]) begin
                    step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
                end else begin
                    step_acc = {step_acc[2*XLEN-2:0], 1'b0};
                end
            end else begin
                sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} +
                           {1'b0, {XLEN{step_acc[0]}} & opb_q};
                step_acc = {sum, step_acc[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        // The fast product is already signed, so only iterative magnitudes need fixing.
        neg_en = sign_q && (funct3_q[2] || !FAST_MUL_EN);
        prod   = neg_en ? -acc_q : acc_q;
        sel    = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (funct3_q[2]) begin
            fin_res = neg_en ? -sel : sel;
        end else if (funct3_q[1:0] == 2'b00) begin
            fin_res = prod[XLEN-1:0];
        end else begin
            fin_res = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        res_d    = res_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    funct3_d = funct3_i;
                    sign_d   = sign_in;
                    cnt_d    = CntW'(Steps - 1);
                    opb_d    = rs2_abs;
                    acc_d    = {{XLEN{1'b0}}, rs1_abs};
                    if (funct3_i[2]) begin
                        if (!DIVISION_EN) begin
                            res_d   = '0;
                            state_d = StDone;
                        end else if (div_zero) begin
                            res_d   = funct3_i[1] ? rs1_i : '1;
                            state_d = StDone;
                        end else if (div_ovf) begin
                            res_d   = funct3_i[1] ? '0 : rs1_i;
                            state_d = StDone;
                        end else begin
                            state_d = StBusy;
                        end
                    end else if (FAST_MUL_EN) begin
                        acc_d   = fast_prod;
                        state_d = StFin;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                res_d   = fin_res;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            funct3_q <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign valid_o = (state_q == StDone) && !abort_i;
    assign res_o   = valid_o ? res_q : '0;

endmodule
